game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Game sequencer for the Pac-Man datapath. Owns the dot-alive mask that
//  color_mapper reads, and credits score from its per-pixel kill_10 requests.
//  Detects pac/ghost collision, tracks lives and level, and runs the round
//  FSM. Drives freeze/respawn to the sprite movers. Sits beside color_mapper,
//  clocked by Clk, frame-paced by VGA VS.
// PARAMETERS
//  NUM_DOTS      10   dot count; width of kill/alive masks
//  LIVES         3    lives loaded at reset and on new game
//  READY_FRAMES  60   frames held in READY/CLEAR before resuming
//  DEATH_FRAMES  90   frames held in DYING
//  SCORE_W       8    score width; saturates at all-ones
// PORTS
//  Clk        in   1         system clock; sole clock domain
//  Reset      in   1         synchronous, active-high
//  frame_clk  in   1         VGA VS, async; rising edge = one frame
//  start      in   1         start key, async level; rising edge acts
//  kill_10    in   NUM_DOTS  per-pixel dot-eaten requests from color_mapper
//  collide    in   1         is_pac & is_ghost for the current pixel
//  alive_10   out  NUM_DOTS  dots still present (feeds color_mapper)
//  score      out  SCORE_W   dots eaten, all levels
//  lives      out  2         remaining lives
//  level      out  4         levels cleared, wraps 15->0
//  state      out  3         game_state_t encoding
//  freeze     out  1         1 = movers hold position
//  respawn    out  1         1-cycle pulse: movers reload start positions
// BEHAVIOUR
//  Reset: alive=all 1, score=0, lives=LIVES, level=0, state=IDLE,
//   freeze=1, respawn=0, frame counter=0.
//  frame_clk, start: 2-flop sync, then rising-edge detect.
//   Gives 1-Clk pulses frame_tick / start_tick, 3 Clk after the async edge.
//  States:
//   IDLE -start_tick-> READY
//   READY: counts READY_FRAMES frame_ticks, then -> PLAY
//   PLAY: on all dots eaten -> CLEAR; on collide -> DYING
//   DYING: lives-=1 on entry; after DEATH_FRAMES ticks:
//    lives==0 -> OVER, else -> READY
//   CLEAR: after READY_FRAMES ticks: alive=all 1, level+=1, -> READY
//   OVER: start_tick -> reload score=0, lives=LIVES, level=0, alive=all 1,
//    then -> READY
//  freeze=0 only in PLAY. respawn pulses on the Clk that enters READY.
//  PLAY, every Clk: newly = alive & kill_10; alive <= alive & ~kill_10.
//   score <= sat(score + popcount(newly)). Kills ignored outside PLAY.
//   Repeat kills of an already-dead dot add nothing.
//  Same-cycle kill and collide: the kill is credited. If that kill clears
//   the last dot, CLEAR wins over DYING. Otherwise -> DYING.
//  Frame counter clears on every state entry and advances only on
//   frame_tick. Exit occurs on the tick that reaches the count.
//  Reset mid-state: returns to reset values on the next edge; no pulse.
//  start_tick outside IDLE/OVER is ignored.
//  All outputs are registered; alive_10 changes 1 Clk after the kill.
// STRUCTURE
//  pac_pkg: game_state_t enum {IDLE,READY,PLAY,DYING,CLEAR,OVER}
//   (3-bit), plus default constants for LIVES/READY_FRAMES/DEATH_FRAMES.
//  Sub-module sync_edge_pulse (2-flop sync + rise detect, 1-bit).
//   Instantiated twice: frame_clk and start.
//  Popcount is a function in pac_pkg.
// TESTING
//  1 Reset, start, 60 frames -> respawn pulse at READY entry; PLAY with
//    freeze=0 after tick 60.
//  2 PLAY, kill_10=10'h005 held 500 Clk -> alive=10'h3FA, score=2
//    exactly once.
//  3 Same cycle: kill_10=10'h200 with alive=10'h200, plus collide=1
//    -> CLEAR, lives unchanged. After 60 frames: level=1, alive=10'h3FF.
//  4 Three collisions with DEATH_FRAMES elapsed each -> lives 2,1,0;
//    OVER after third. start_tick -> score=0, lives=3.
//  5 score=8'hFF, eat 1 dot -> score stays 8'hFF.
//  6 Reset asserted mid-DYING -> next edge IDLE, lives=3, freeze=1,
//    no respawn pulse.

Source files
------------

// File: rtl/pac_pkg.sv
// Shared types and defaults for the Pac-Man game sequencer.
package pac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  localparam int LIVES_DEF        = 3;
  localparam int READY_FRAMES_DEF = 60;
  localparam int DEATH_FRAMES_DEF = 90;

  // Count of set bits; callers zero-extend narrower masks into v.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/sync_edge_pulse.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge_pulse (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic pulse
);

  logic [2:0] sr;

  // Shift the async input through the sync chain; pulse on a 0->1 step.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], din};
      pulse <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Round sequencer: dot mask, score, lives, level and freeze/respawn control.
module game_state_ctrl
  import pac_pkg::*;
#(
  parameter int NUM_DOTS     = 10,
  parameter int LIVES        = LIVES_DEF,
  parameter int READY_FRAMES = READY_FRAMES_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int SCORE_W      = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                start,
  input  logic [NUM_DOTS-1:0] kill_10,
  input  logic                collide,
  output logic [NUM_DOTS-1:0] alive_10,
  output logic [SCORE_W-1:0]  score,
  output logic [1:0]          lives,
  output logic [3:0]          level,
  output logic [2:0]          state,
  output logic                freeze,
  output logic                respawn
);

  localparam int MAXF = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  localparam int SW   = SCORE_W + 7;

  logic frame_tick, start_tick;

  sync_edge_pulse u_frame (.Clk(Clk), .Reset(Reset), .din(frame_clk), .pulse(frame_tick));
  sync_edge_pulse u_start (.Clk(Clk), .Reset(Reset), .din(start),     .pulse(start_tick));

  game_state_t         st, st_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [NUM_DOTS-1:0] alive_n, newly;
  logic [SCORE_W-1:0]  score_n;
  logic [1:0]          lives_n;
  logic [3:0]          level_n;
  logic                respawn_n;
  logic [SW-1:0]       sum;

  // Next-state and next-datapath values; every state entry clears the frame counter.
  always_comb begin
    st_n      = st;
    cnt_n     = frame_tick ? cnt + CW'(1) : cnt;
    alive_n   = alive_10;
    score_n   = score;
    lives_n   = lives;
    level_n   = level;
    respawn_n = 1'b0;
    newly     = alive_10 & kill_10;
    sum       = SW'(score) + SW'(popcount(32'(newly)));
    unique case (st)
      IDLE: if (start_tick) begin
        st_n = READY; cnt_n = '0; respawn_n = 1'b1;
      end
      READY: if (frame_tick && cnt == CW'(READY_FRAMES - 1)) begin
        st_n = PLAY; cnt_n = '0;
      end
      PLAY: begin
        alive_n = alive_10 & ~kill_10;
        score_n = (sum > SW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        if (alive_n == '0) begin
          st_n = CLEAR; cnt_n = '0;
        end else if (collide) begin
          st_n = DYING; cnt_n = '0;
          if (lives != 2'd0) lives_n = lives - 2'd1;
        end
      end
      DYING: if (frame_tick && cnt == CW'(DEATH_FRAMES - 1)) begin
        cnt_n = '0;
        if (lives == 2'd0) st_n = OVER;
        else begin
          st_n = READY; respawn_n = 1'b1;
        end
      end
      CLEAR: if (frame_tick && cnt == CW'(READY_FRAMES - 1)) begin
        st_n = READY; cnt_n = '0; respawn_n = 1'b1;
        alive_n = '1; level_n = level + 4'd1;
      end
      OVER: if (start_tick) begin
        st_n = READY; cnt_n = '0; respawn_n = 1'b1;
        score_n = '0; lives_n = 2'(LIVES); level_n = '0; alive_n = '1;
      end
      default: begin
        st_n = IDLE; cnt_n = '0;
      end
    endcase
  end

  // Register state, datapath and all outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st       <= IDLE;
      cnt      <= '0;
      alive_10 <= '1;
      score    <= '0;
      lives    <= 2'(LIVES);
      level    <= '0;
      freeze   <= 1'b1;
      respawn  <= 1'b0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      alive_10 <= alive_n;
      score    <= score_n;
      lives    <= lives_n;
      level    <= level_n;
      freeze   <= (st_n != PLAY);
      respawn  <= respawn_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: vector table in PLAY plus round sequences.
module tb_game_state_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_PLAY = 3'd2,
                         S_DYING = 3'd3, S_CLEAR = 3'd4, S_OVER = 3'd5;

  logic       Clk = 0, Reset = 1, frame_clk = 0, start = 0, collide = 0;
  logic [9:0] kill_10 = '0;
  logic [9:0] alive_10;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state;
  logic       freeze, respawn;

  int nvec = 0, nmis = 0, rsp_cnt = 0;

  game_state_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .kill_10(kill_10), .collide(collide), .alive_10(alive_10), .score(score),
    .lives(lives), .level(level), .state(state), .freeze(freeze), .respawn(respawn)
  );

  always #5 Clk = ~Clk;

  // respawn is a one-cycle pulse; count it away from the active edge.
  always @(negedge Clk) if (respawn) rsp_cnt++;

  typedef struct {
    logic [9:0] kill;
    logic       coll;
    logic [9:0] alive;
    logic [7:0] score;
    logic [2:0] st;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_clk = 1;
      repeat (4) @(negedge Clk);
      frame_clk = 0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic press_start();
    @(negedge Clk) start = 1;
    repeat (6) @(negedge Clk);
    start = 0;
    repeat (6) @(negedge Clk);
  endtask

  // Drive one cycle of kill/collide and sample just after the edge that registers it.
  task automatic pulse_in(input logic [9:0] k, input logic c);
    @(negedge Clk) begin kill_10 = k; collide = c; end
    @(posedge Clk); #1;
    @(negedge Clk) begin kill_10 = '0; collide = 0; end
  endtask

  initial begin
    vt[0] = '{10'h005, 0, 10'h3FA, 8'd2, S_PLAY};
    vt[1] = '{10'h005, 0, 10'h3FA, 8'd2, S_PLAY};
    vt[2] = '{10'h000, 0, 10'h3FA, 8'd2, S_PLAY};
    vt[3] = '{10'h0F0, 0, 10'h30A, 8'd6, S_PLAY};
    vt[4] = '{10'h0F8, 0, 10'h302, 8'd7, S_PLAY};
    vt[5] = '{10'h100, 0, 10'h202, 8'd8, S_PLAY};
    vt[6] = '{10'h002, 0, 10'h200, 8'd9, S_PLAY};

    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("rst_state", state, S_IDLE);
    chk("rst_alive", alive_10, 10'h3FF);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_respawn_cnt", rsp_cnt, 0);

    // Round start: respawn once on READY entry, then 60 frames to PLAY.
    press_start();
    chk("start_state", state, S_READY);
    chk("start_respawn", rsp_cnt, 1);
    pulse_in(10'h3FF, 0);
    chk("ready_kill_ignored", alive_10, 10'h3FF);
    frames(59);
    chk("ready_59", state, S_READY);
    frames(1);
    chk("ready_60_play", state, S_PLAY);
    chk("play_freeze", freeze, 0);
    press_start();
    chk("play_start_ignored", state, S_PLAY);

    // Held kill credits once.
    @(negedge Clk) kill_10 = 10'h005;
    repeat (500) @(negedge Clk);
    kill_10 = '0;
    chk("held_alive", alive_10, 10'h3FA);
    chk("held_score", score, 2);

    for (int i = 0; i < 7; i++) begin
      pulse_in(vt[i].kill, vt[i].coll);
      chk($sformatf("vec%0d_alive", i), alive_10, vt[i].alive);
      chk($sformatf("vec%0d_score", i), score, vt[i].score);
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
    end

    // Last dot and collide together: CLEAR wins, lives kept.
    pulse_in(10'h200, 1);
    chk("clear_state", state, S_CLEAR);
    chk("clear_lives", lives, 3);
    chk("clear_score", score, 10);
    chk("clear_alive", alive_10, 0);
    chk("clear_freeze", freeze, 1);
    frames(60);
    chk("clear_ready", state, S_READY);
    chk("clear_level", level, 1);
    chk("clear_refill", alive_10, 10'h3FF);
    chk("clear_respawn", rsp_cnt, 2);
    frames(60);
    chk("lvl1_play", state, S_PLAY);

    // Three deaths to game over.
    for (int d = 0; d < 3; d++) begin
      pulse_in(10'h000, 1);
      chk($sformatf("die%0d_state", d), state, S_DYING);
      chk($sformatf("die%0d_lives", d), lives, 2 - d);
      if (d == 0) begin
        press_start();
        chk("dying_start_ignored", state, S_DYING);
      end
      frames(89);
      chk($sformatf("die%0d_hold", d), state, S_DYING);
      frames(1);
      chk($sformatf("die%0d_exit", d), state, (d == 2) ? S_OVER : S_READY);
      if (d != 2) frames(60);
    end
    chk("over_freeze", freeze, 1);
    press_start();
    chk("newgame_state", state, S_READY);
    chk("newgame_score", score, 0);
    chk("newgame_lives", lives, 3);
    chk("newgame_level", level, 0);
    chk("newgame_alive", alive_10, 10'h3FF);

    // Reset in the middle of DYING.
    frames(60);
    pulse_in(10'h000, 1);
    chk("pre_rst_dying", state, S_DYING);
    frames(10);
    rsp_cnt = 0;
    @(negedge Clk) Reset = 1;
    @(posedge Clk); #1;
    chk("midrst_state", state, S_IDLE);
    chk("midrst_lives", lives, 3);
    chk("midrst_freeze", freeze, 1);
    repeat (3) @(negedge Clk);
    Reset = 0;
    repeat (3) @(negedge Clk);
    chk("midrst_no_respawn", rsp_cnt, 0);

    // Score saturation after 25 cleared levels (level wraps past 15).
    press_start();
    frames(60);
    for (int l = 0; l < 25; l++) begin
      pulse_in(10'h3FF, 0);
      frames(120);
    end
    chk("sat_pre_score", score, 250);
    chk("sat_level_wrap", level, 9);
    chk("sat_state", state, S_PLAY);
    pulse_in(10'h01F, 0);
    chk("sat_255", score, 8'hFF);
    pulse_in(10'h020, 0);
    chk("sat_hold", score, 8'hFF);
    chk("sat_alive", alive_10, 10'h3C0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
